// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The sgn request line exists only when DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
   parameter int unsigned WL = 8
);
   logic          start;
   logic [WL-1:0] dividend;
   logic [WL-1:0] divisor;
   logic [WL-1:0] quotient;
   logic [WL-1:0] remainder;
   logic          busy;
   logic          done;
   logic          dz;
`ifdef DIVIDER_SIGNED_EN
   logic          sgn;
`endif

   modport master (
`ifdef DIVIDER_SIGNED_EN
      output sgn,
`endif
      output start, dividend, divisor,
      input  quotient, remainder, busy, done, dz
   );

   modport slave (
`ifdef DIVIDER_SIGNED_EN
      input  sgn,
`endif
      input  start, dividend, divisor,
      output quotient, remainder, busy, done, dz
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, with divide-by-zero flag.
// Optional two's complement operation when DIVIDER_SIGNED_EN is defined.
module seq_divider #(
   parameter int unsigned WL = 8
) (
   input  logic         CLK,
   input  logic         RST,
   seq_divider_if.slave bus
);
   localparam int unsigned CW = $clog2(WL);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2, ZERO = 2'd3} state_t;

   state_t        state, state_nxt;
   logic [WL-1:0] p, p_nxt, a, a_nxt, dvs, dvs_nxt;
   logic [WL-1:0] q_r, q_nxt, r_r, r_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          busy_r, busy_nxt, done_r, done_nxt, dz_r, dz_nxt;
   logic          negq, negq_nxt, negr, negr_nxt;
   logic          sgn_c;
   logic [WL-1:0] dvd_mag_c, dvs_mag_c;
   logic [WL:0]   p_sh_c, t_c;

`ifdef DIVIDER_SIGNED_EN
   assign sgn_c = bus.sgn;
`else
   assign sgn_c = 1'b0;
`endif

   // Signed operands are reduced to magnitudes so the core stays unsigned
   assign dvd_mag_c = (sgn_c && bus.dividend[WL-1]) ? WL'(-bus.dividend) : bus.dividend;
   assign dvs_mag_c = (sgn_c && bus.divisor[WL-1])  ? WL'(-bus.divisor)  : bus.divisor;

   // P < divisor keeps the trial difference within WL+1 signed bits
   assign p_sh_c = {p, a[WL-1]};
   assign t_c    = p_sh_c - {1'b0, dvs};

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         p      <= '0;
         a      <= '0;
         dvs    <= '0;
         cnt    <= '0;
         q_r    <= '0;
         r_r    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
         negq   <= 1'b0;
         negr   <= 1'b0;
      end else begin
         state  <= state_nxt;
         p      <= p_nxt;
         a      <= a_nxt;
         dvs    <= dvs_nxt;
         cnt    <= cnt_nxt;
         q_r    <= q_nxt;
         r_r    <= r_nxt;
         busy_r <= busy_nxt;
         done_r <= done_nxt;
         dz_r   <= dz_nxt;
         negq   <= negq_nxt;
         negr   <= negr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      p_nxt     = p;
      a_nxt     = a;
      dvs_nxt   = dvs;
      cnt_nxt   = cnt;
      q_nxt     = q_r;
      r_nxt     = r_r;
      busy_nxt  = busy_r;
      done_nxt  = 1'b0;
      dz_nxt    = dz_r;
      negq_nxt  = negq;
      negr_nxt  = negr;

      case (state)
         IDLE: begin
            if (bus.start) begin
               busy_nxt = 1'b1;
               p_nxt    = '0;
               cnt_nxt  = CW'(WL - 1);
               negq_nxt = sgn_c & (bus.dividend[WL-1] ^ bus.divisor[WL-1]);
               negr_nxt = sgn_c & bus.dividend[WL-1];
               // Divide-by-zero keeps the raw dividend for the remainder output
               if (bus.divisor == '0) begin
                  a_nxt     = bus.dividend;
                  dvs_nxt   = '0;
                  state_nxt = ZERO;
               end else begin
                  a_nxt     = dvd_mag_c;
                  dvs_nxt   = dvs_mag_c;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            p_nxt   = t_c[WL] ? p_sh_c[WL-1:0] : t_c[WL-1:0];
            a_nxt   = {a[WL-2:0], ~t_c[WL]};
            cnt_nxt = cnt - CW'(1);
            if (cnt == '0) begin
               state_nxt = FIN;
            end
         end
         FIN: begin
            q_nxt     = negq ? WL'(-a) : a;
            r_nxt     = negr ? WL'(-p) : p;
            dz_nxt    = 1'b0;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         ZERO: begin
            q_nxt     = '1;
            r_nxt     = a;
            dz_nxt    = 1'b1;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.quotient  = q_r;
   assign bus.remainder = r_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.dz        = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WL=4 and WL=8.
// Signed vectors run only when DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;

   seq_divider_if #(.WL(4)) b4 ();
   seq_divider_if #(.WL(8)) b8 ();

   seq_divider #(.WL(4)) u4 (.CLK(CLK), .RST(RST), .bus(b4));
   seq_divider #(.WL(8)) u8 (.CLK(CLK), .RST(RST), .bus(b8));

   always #5 CLK = ~CLK;

   task automatic start4(input logic [3:0] x, input logic [3:0] y, input logic s);
      @(negedge CLK);
      b4.start = 1'b1; b4.dividend = x; b4.divisor = y;
`ifdef DIVIDER_SIGNED_EN
      b4.sgn = s;
`else
      if (s) $display("note: sgn ignored in unsigned build");
`endif
      @(posedge CLK);
      #1 b4.start = 1'b0;
   endtask

   task automatic start8(input logic [7:0] x, input logic [7:0] y);
      @(negedge CLK);
      b8.start = 1'b1; b8.dividend = x; b8.divisor = y;
      @(posedge CLK);
      #1 b8.start = 1'b0;
   endtask

   // Cycles from the accepting edge to the done cycle; -1 on timeout
   task automatic wait4(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge CLK); @(negedge CLK);
         if (b4.done) begin lat = n; break; end
      end
   endtask

   task automatic wait8(output int lat);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge CLK); @(negedge CLK);
         if (b8.done) begin lat = n; break; end
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      checks++;
      if ({b4.quotient, b4.remainder, b4.busy, b4.done, b4.dz} !== 11'd0) begin
         errors++; $display("FAIL reset4: got %b want 0", {b4.quotient, b4.remainder, b4.busy, b4.done, b4.dz});
      end
      checks++;
      if ({b8.quotient, b8.remainder, b8.busy, b8.done, b8.dz} !== 19'd0) begin
         errors++; $display("FAIL reset8: got %b want 0", {b8.quotient, b8.remainder, b8.busy, b8.done, b8.dz});
      end
   endtask

   task automatic test_basic4();
      int lat;
      start4(4'b1101, 4'b0010, 1'b0);
      @(negedge CLK);
      checks++;
      if (b4.busy !== 1'b1 || b4.done !== 1'b0 || b4.quotient !== 4'd0) begin
         errors++; $display("FAIL basic4_run: busy=%b done=%b q=%0d want busy=1 done=0 q=0", b4.busy, b4.done, b4.quotient);
      end
      wait4(lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL basic4_lat: got %0d want 5", lat); end
      checks++;
      if (b4.quotient !== 4'b0110 || b4.remainder !== 4'b0001 || b4.dz !== 1'b0 || b4.busy !== 1'b0) begin
         errors++; $display("FAIL basic4_res: q=%b r=%b dz=%b busy=%b want q=0110 r=0001 dz=0 busy=0",
                             b4.quotient, b4.remainder, b4.dz, b4.busy);
      end
      @(negedge CLK);
      checks++;
      if (b4.done !== 1'b0) begin errors++; $display("FAIL basic4_pulse: done=%b want 0", b4.done); end
   endtask

   task automatic test_back_to_back();
      int lat;
      start8(8'd255, 8'd16);
      wait8(lat);
      checks++;
      if (lat !== 9 || b8.quotient !== 8'd15 || b8.remainder !== 8'd15) begin
         errors++; $display("FAIL b2b_first: lat=%0d q=%0d r=%0d want lat=9 q=15 r=15", lat, b8.quotient, b8.remainder);
      end
      // Issue the next start inside the done cycle
      b8.start = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
      @(posedge CLK);
      #1 b8.start = 1'b0;
      wait8(lat);
      checks++;
      if (lat !== 9 || b8.quotient !== 8'd14 || b8.remainder !== 8'd2 || b8.busy !== 1'b0) begin
         errors++; $display("FAIL b2b_second: lat=%0d q=%0d r=%0d busy=%b want lat=9 q=14 r=2 busy=0",
                             lat, b8.quotient, b8.remainder, b8.busy);
      end
   endtask

   task automatic test_div_zero();
      int lat;
      start8(8'd9, 8'd0);
      wait8(lat);
      checks++;
      if (lat !== 1 || b8.dz !== 1'b1 || b8.quotient !== 8'hFF || b8.remainder !== 8'h09 || b8.busy !== 1'b0) begin
         errors++; $display("FAIL dz: lat=%0d dz=%b q=%h r=%h busy=%b want lat=1 dz=1 q=ff r=09 busy=0",
                             lat, b8.dz, b8.quotient, b8.remainder, b8.busy);
      end
      start8(8'd9, 8'd3);
      @(negedge CLK);
      checks++;
      if (b8.dz !== 1'b1 || b8.quotient !== 8'hFF) begin
         errors++; $display("FAIL dz_hold: dz=%b q=%h want dz=1 q=ff during run", b8.dz, b8.quotient);
      end
      wait8(lat);
      checks++;
      if (lat !== 9 || b8.dz !== 1'b0 || b8.quotient !== 8'd3 || b8.remainder !== 8'd0) begin
         errors++; $display("FAIL dz_clear: lat=%0d dz=%b q=%0d r=%0d want lat=9 dz=0 q=3 r=0",
                             lat, b8.dz, b8.quotient, b8.remainder);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      start8(8'd200, 8'd3);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      b8.start = 1'b1; b8.dividend = 8'd50; b8.divisor = 8'd5;
      @(posedge CLK);
      #1 b8.start = 1'b0;
      // Three edges already consumed, so done arrives six edges later
      wait8(lat);
      checks++;
      if (lat !== 6 || b8.quotient !== 8'd66 || b8.remainder !== 8'd2) begin
         errors++; $display("FAIL ignore_start: lat=%0d q=%0d r=%0d want lat=6 q=66 r=2", lat, b8.quotient, b8.remainder);
      end
      repeat (3) @(negedge CLK);
      checks++;
      if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin
         errors++; $display("FAIL ignore_idle: busy=%b done=%b want 0 0", b8.busy, b8.done);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      start8(8'd200, 8'd3);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      checks++;
      if ({b8.quotient, b8.remainder, b8.busy, b8.done, b8.dz} !== 19'd0) begin
         errors++; $display("FAIL reset_mid: got q=%0d r=%0d busy=%b done=%b dz=%b want all 0",
                             b8.quotient, b8.remainder, b8.busy, b8.done, b8.dz);
      end
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      seen = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge CLK);
         if (b8.done || b8.busy) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL reset_nodone: got %0d active cycles want 0", seen); end
      start8(8'd10, 8'd4);
      wait8(lat);
      checks++;
      if (lat !== 9 || b8.quotient !== 8'd2 || b8.remainder !== 8'd2) begin
         errors++; $display("FAIL reset_fresh: lat=%0d q=%0d r=%0d want lat=9 q=2 r=2", lat, b8.quotient, b8.remainder);
      end
   endtask

   task automatic test_boundaries();
      logic [7:0] vec [5][4];
      int lat;
      vec = '{'{8'd0, 8'd1, 8'd0, 8'd0}, '{8'd1, 8'd255, 8'd0, 8'd1}, '{8'd255, 8'd255, 8'd1, 8'd0},
              '{8'd255, 8'd1, 8'd255, 8'd0}, '{8'd128, 8'd3, 8'd42, 8'd2}};
      for (int i = 0; i < 5; i++) begin
         start8(vec[i][0], vec[i][1]);
         wait8(lat);
         checks++;
         if (lat !== 9 || b8.quotient !== vec[i][2] || b8.remainder !== vec[i][3]) begin
            errors++; $display("FAIL bound%0d %0d/%0d: lat=%0d q=%0d r=%0d want lat=9 q=%0d r=%0d", i, vec[i][0], vec[i][1],
                                lat, b8.quotient, b8.remainder, vec[i][2], vec[i][3]);
         end
      end
   endtask

`ifdef DIVIDER_SIGNED_EN
   task automatic test_signed();
      logic [3:0] vec [6][5];
      int lat;
      // dividend, divisor, sgn, quotient, remainder
      vec = '{'{4'b1001, 4'b0010, 4'd1, 4'b1101, 4'b1111},
              '{4'b1000, 4'b1111, 4'd1, 4'b1000, 4'b0000},
              '{4'b1001, 4'b0010, 4'd0, 4'b0100, 4'b0001},
              '{4'b0111, 4'b1110, 4'd1, 4'b1101, 4'b0001},
              '{4'b1001, 4'b1110, 4'd1, 4'b0011, 4'b1111},
              '{4'b1001, 4'b0000, 4'd1, 4'b1111, 4'b1001}};
      for (int i = 0; i < 6; i++) begin
         start4(vec[i][0], vec[i][1], vec[i][2][0]);
         wait4(lat);
         checks++;
         if (lat !== ((vec[i][1] == 4'd0) ? 1 : 5) || b4.quotient !== vec[i][3] || b4.remainder !== vec[i][4] ||
             b4.dz !== (vec[i][1] == 4'd0)) begin
            errors++; $display("FAIL signed%0d: lat=%0d q=%b r=%b dz=%b want q=%b r=%b", i, lat,
                                b4.quotient, b4.remainder, b4.dz, vec[i][3], vec[i][4]);
         end
      end
   endtask
`endif

   initial begin
      b4.start = 1'b0; b4.dividend = '0; b4.divisor = '0;
      b8.start = 1'b0; b8.dividend = '0; b8.divisor = '0;
`ifdef DIVIDER_SIGNED_EN
      b4.sgn = 1'b0;
      b8.sgn = 1'b0;
`endif
      repeat (3) @(negedge CLK);
      test_reset();
      RST = 1'b0;
      test_basic4();
      test_back_to_back();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_boundaries();
`ifdef DIVIDER_SIGNED_EN
      test_signed();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
